// File: rtl/snn_image_loader_if.sv
// Handshake and bus bundle between the image loader and its neighbours:
// UART receiver/transmitter, the shared input-unit RAM and the SNN core.
interface snn_image_loader_if;
  // UART receive side
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  // Input-unit RAM port (owned by the loader)
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       ram_we;
  // SNN core side
  logic [9:0] core_addr;
  logic       start;
  logic       done;
  logic [3:0] digit;
  // UART transmit side
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  // Status
  logic [3:0] result;
  logic       busy;

  // Loader side: drives the acknowledges, RAM port, start and transmit.
  modport master (
    input  rx_rdy, rx_data, core_addr, done, digit, tx_done,
    output clr_rx_rdy, ram_addr, ram_d, ram_we, start, tx_start, tx_data, result, busy
  );

  // Environment side: receiver, RAM, core and transmitter.
  modport slave (
    output rx_rdy, rx_data, core_addr, done, digit, tx_done,
    input  clr_rx_rdy, ram_addr, ram_d, ram_we, start, tx_start, tx_data, result, busy
  );
endinterface

// File: rtl/snn_image_loader.sv
// Image loader front end for the SNN core.
// Receives NUM_BYTES bytes, unpacks each LSB first into eight single-bit
// writes of the input-unit RAM, launches the core, waits for its result and
// sends the digit back as one ASCII byte. While the core runs, the RAM
// address is handed over to the core's read address.
module snn_image_loader #(
  parameter int unsigned NUM_BYTES  = 98,
  parameter logic [7:0]  ASCII_BASE = 8'h30
) (
  input  logic               clk,
  input  logic               rst_n,
  snn_image_loader_if.master bus
);

  localparam logic [9:0] LP_NUM_PIXELS = 10'(NUM_BYTES * 8);

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_UNPACK    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_CORE = 3'd3,
    S_SEND      = 3'd4,
    S_WAIT_TX   = 3'd5
  } state_t;

  state_t     r_state;
  logic [9:0] r_wr_addr;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [3:0] r_result;

  logic [9:0] w_wr_addr_inc;
  logic       w_in_load;
  logic       w_in_unpack;

  assign w_wr_addr_inc = r_wr_addr + 10'd1;
  assign w_in_load     = (r_state == S_LOAD);
  assign w_in_unpack   = (r_state == S_UNPACK);

  // Sequencer: byte intake, bit unpacking, core launch and result return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOAD;
      r_wr_addr <= 10'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_result  <= 4'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.rx_rdy) begin
            r_shift <= bus.rx_data;
            r_state <= S_UNPACK;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_UNPACK: begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_wr_addr <= w_wr_addr_inc;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            // Last pixel of the image just written: hand over to the core.
            if (w_wr_addr_inc == LP_NUM_PIXELS) begin
              r_state <= S_START;
            end else begin
              r_state <= S_LOAD;
            end
          end else begin
            r_state <= S_UNPACK;
          end
        end
        S_START: begin
          r_wr_addr <= 10'd0;
          r_state   <= S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          if (bus.done) begin
            r_result <= bus.digit;
            r_state  <= S_SEND;
          end else begin
            r_state <= S_WAIT_CORE;
          end
        end
        S_SEND: begin
          r_state <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (bus.tx_done) begin
            r_state <= S_LOAD;
          end else begin
            r_state <= S_WAIT_TX;
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  // Output decode from registered state; the byte acknowledge follows
  // rx_rdy within the accept cycle so the receiver clears on that edge.
  always_comb begin
    bus.clr_rx_rdy = 1'b0;
    bus.ram_we     = 1'b0;
    bus.ram_d      = 1'b0;
    bus.ram_addr   = bus.core_addr;
    bus.start      = 1'b0;
    bus.tx_start   = 1'b0;
    if (w_in_load) begin
      bus.clr_rx_rdy = bus.rx_rdy;
      bus.ram_addr   = r_wr_addr;
    end else if (w_in_unpack) begin
      bus.ram_we   = 1'b1;
      bus.ram_d    = r_shift[0];
      bus.ram_addr = r_wr_addr;
    end else begin
      bus.start    = (r_state == S_START);
      bus.tx_start = (r_state == S_SEND);
    end
  end

  assign bus.result  = r_result;
  assign bus.tx_data = ASCII_BASE + {4'd0, r_result};
  assign bus.busy    = (!w_in_load) || (r_wr_addr != 10'd0);

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed self-checking bench for snn_image_loader.
module tb_snn_image_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snn_image_loader_if bus();

  snn_image_loader #(.NUM_BYTES(98), .ASCII_BASE(8'h30)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int bad_addr_cnt = 0;
  logic ram_model [0:1023];

  // RAM / start monitor, sampled on the active edge with pre-edge values
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.ram_addr >= 10'd784) bad_addr_cnt <= bad_addr_cnt + 1;
      else ram_model[bus.ram_addr] <= bus.ram_d;
    end
    if (bus.start === 1'b1) start_cnt <= start_cnt + 1;
  end

  function automatic logic [7:0] img_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Present a byte and wait for its acknowledge; returns at posedge+1 after accept
  task automatic accept_byte(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.clr_rx_rdy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL accept_timeout: clr_rx_rdy got 0 expected 1 (byte %h)", b);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus.clr_rx_rdy, bus.ram_we, bus.ram_d, bus.start, bus.tx_start, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got %b expected 000000", tag,
               {bus.clr_rx_rdy, bus.ram_we, bus.ram_d, bus.start, bus.tx_start, bus.busy});
    end
    checks++;
    if (bus.ram_addr !== 10'd0) begin
      errors++; $display("FAIL %s_ram_addr: got %h expected 000", tag, bus.ram_addr);
    end
    checks++;
    if (bus.result !== 4'd0) begin
      errors++; $display("FAIL %s_result: got %h expected 0", tag, bus.result);
    end
    checks++;
    if (bus.tx_data !== 8'h30) begin
      errors++; $display("FAIL %s_tx_data: got %h expected 30", tag, bus.tx_data);
    end
  endtask

  task automatic test_reset();
    bus.rx_rdy = 1'b0; bus.rx_data = 8'd0; bus.core_addr = 10'd0;
    bus.done = 1'b0; bus.digit = 4'd0; bus.tx_done = 1'b0;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_unpack();
    accept_byte(8'hFF);
    bus.rx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b1) begin
      errors++; $display("FAIL mid_unpack_we: got %b expected 1", bus.ram_we);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_bit_mapping();
    logic [7:0] exp;
    exp = 8'hA5;
    accept_byte(exp);
    bus.rx_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_d, bus.clr_rx_rdy} !== {1'b1, 10'(k), exp[k], 1'b0}) begin
        errors++;
        $display("FAIL bitmap_w%0d: got we=%b addr=%h d=%b clr=%b expected we=1 addr=%h d=%b clr=0",
                 k, bus.ram_we, bus.ram_addr, bus.ram_d, bus.clr_rx_rdy, 10'(k), exp[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_image();
    int w0, s0, b0, n, mm;
    logic [9:0] addr_at_start;
    logic [7:0] pb;
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.core_addr = 10'h155;
    w0 = wr_cnt; s0 = start_cnt; b0 = bad_addr_cnt;
    for (int i = 0; i < 98; i++) accept_byte(img_byte(i));
    bus.rx_rdy = 1'b0;
    n = 0; addr_at_start = 10'd0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.start === 1'b1 && n == 0) begin
        n = c;
        addr_at_start = bus.ram_addr;
      end
    end
    checks++;
    if (n != 9) begin errors++; $display("FAIL start_latency: got %0d expected 9", n); end
    checks++;
    if (addr_at_start !== 10'h155) begin
      errors++; $display("FAIL start_ram_addr: got %h expected 155", addr_at_start);
    end
    checks++;
    if (wr_cnt - w0 != 784) begin errors++; $display("FAIL write_count: got %0d expected 784", wr_cnt - w0); end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL start_count: got %0d expected 1", start_cnt - s0); end
    checks++;
    if (bad_addr_cnt != b0) begin errors++; $display("FAIL addr_overrun: got %0d expected 0", bad_addr_cnt - b0); end
    mm = 0;
    for (int i = 0; i < 98; i++) begin
      pb = img_byte(i);
      for (int k = 0; k < 8; k++) if (ram_model[i * 8 + k] !== pb[k]) mm++;
    end
    checks++;
    if (mm != 0) begin errors++; $display("FAIL image_content: got %0d wrong pixels expected 0", mm); end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_mux();
    bus.core_addr = 10'h2A7;
    @(negedge clk);
    checks++;
    if ({bus.ram_addr, bus.ram_we, bus.ram_d, bus.busy} !== {10'h2A7, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL addr_mux: got addr=%h we=%b d=%b busy=%b expected addr=2a7 we=0 d=0 busy=1",
               bus.ram_addr, bus.ram_we, bus.ram_d, bus.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure_hold();
    int clr_seen;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'hFF;
    clr_seen = 0;
    // Stray tx_done while the core is still running
    bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.clr_rx_rdy === 1'b1 || bus.tx_start === 1'b1) clr_seen++;
    end
    checks++;
    if (clr_seen != 0) begin errors++; $display("FAIL hold_in_wait_core: got %0d events expected 0", clr_seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_result_path();
    bus.done = 1'b1; bus.digit = 4'd7;
    @(negedge clk);
    checks++;
    if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_early: got %b expected 0", bus.tx_start); end
    @(posedge clk); #1;
    bus.done = 1'b0; bus.digit = 4'd0;
    @(negedge clk);
    checks++;
    if ({bus.tx_start, bus.tx_data, bus.result, bus.clr_rx_rdy} !== {1'b1, 8'h37, 4'd7, 1'b0}) begin
      errors++;
      $display("FAIL send: got tx_start=%b tx_data=%h result=%h clr=%b expected 1 37 7 0",
               bus.tx_start, bus.tx_data, bus.result, bus.clr_rx_rdy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.tx_start, bus.busy, bus.clr_rx_rdy} !== 3'b010) begin
      errors++; $display("FAIL wait_tx: got tx_start/busy/clr=%b expected 010", {bus.tx_start, bus.busy, bus.clr_rx_rdy});
    end
    @(posedge clk); #1;
    bus.tx_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.clr_rx_rdy} !== 2'b10) begin
      errors++; $display("FAIL tx_done_cycle: got busy/clr=%b expected 10", {bus.busy, bus.clr_rx_rdy});
    end
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.clr_rx_rdy} !== 2'b01) begin
      errors++; $display("FAIL back_in_load: got busy/clr=%b expected 01", {bus.busy, bus.clr_rx_rdy});
    end
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_d} !== {1'b1, 10'(k), 1'b1}) begin
        errors++;
        $display("FAIL pending_byte_w%0d: got we=%b addr=%h d=%b expected we=1 addr=%h d=1",
                 k, bus.ram_we, bus.ram_addr, bus.ram_d, 10'(k));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stray_done();
    bus.done = 1'b1; bus.digit = 4'd3; bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.done = 1'b0; bus.digit = 4'd0; bus.tx_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.result, bus.tx_data, bus.tx_start, bus.start, bus.busy} !== {4'd7, 8'h37, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL stray_done: got result=%h tx_data=%h tx_start=%b start=%b busy=%b expected 7 37 0 0 1",
                 bus.result, bus.tx_data, bus.tx_start, bus.start, bus.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_unpack();
    test_bit_mapping();
    test_full_image();
    test_addr_mux();
    test_backpressure_hold();
    test_result_path();
    test_stray_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_image_loader.md
# snn_image_loader

Front-end controller between the UART receiver/transmitter and the SNN inference core. It accepts 98 received bytes and unpacks them into 784 single-bit writes to the shared 1024x1 input-unit RAM, then pulses the core's start. It waits for the core's done and transmits the classified digit back as one ASCII byte. It owns the input RAM port and multiplexes it between its own writes and the core's read address.

## Interface
- Parameters:
  - NUM_BYTES, 98, bytes per image (784 pixels / 8)
  - ASCII_BASE, 8'h30, added to the digit to form the transmitted byte
- Ports:
  - clk  input  1  system clock
  - rst_n  input  1  reset; one clock, reset is asynchronous and active-low
  - rx_rdy  input  1  UART byte pending; level, held until cleared
  - rx_data  input  8  received byte, valid while rx_rdy high
  - clr_rx_rdy  output  1  one-cycle pulse acknowledging the byte
  - ram_addr  output  10  input-unit RAM address
  - ram_d  output  1  RAM write data
  - ram_we  output  1  RAM write enable
  - core_addr  input  10  core's input-unit read address
  - start  output  1  one-cycle pulse launching inference
  - done  input  1  core finished; single-cycle pulse
  - digit  input  4  core result, valid when done is high
  - tx_start  output  1  one-cycle pulse launching a UART transmit
  - tx_data  output  8  byte to transmit
  - tx_done  input  1  UART transmit complete pulse
  - result  output  4  last classified digit, registered
  - busy  output  1  image in progress (load, inference or transmit)

## Operation
- **States:** LOAD, UNPACK, START, WAIT_CORE, SEND, WAIT_TX. Reset state is LOAD.
- **LOAD:**
  - On rx_rdy: latch rx_data into an 8-bit shift register, assert clr_rx_rdy combinationally in the same cycle, and go to UNPACK.
  - Without rx_rdy: stay in LOAD.
- **UNPACK (8 cycles):**
  - Each cycle: ram_we=1, ram_addr=wr_addr, ram_d=shift[0]; shift right; wr_addr+1; bit_cnt+1.
  - Bit order is LSB first, so pixel 8*i+k = bit k of byte i.
  - After the 8th write: if wr_addr has reached 784, go to START; otherwise go to LOAD.
- **START:** start=1 for one cycle; clear wr_addr to 0; go to WAIT_CORE.
- **WAIT_CORE:**
  - ram_addr = core_addr, ram_we=0.
  - On done: register result<=digit and go to SEND.
- **SEND:** tx_start=1 for one cycle; go to WAIT_TX.
- **WAIT_TX:** on tx_done, go to LOAD ready for the next image.
- **Outputs:**
  - tx_data = ASCII_BASE + result, zero-extended 4->8 bits with no saturation; digits 0–9 give 8'h30–8'h39.
  - ram_addr = wr_addr in LOAD/UNPACK and core_addr in START/WAIT_CORE/SEND/WAIT_TX.
  - ram_d=0 whenever ram_we=0.
  - busy = (state != LOAD) | (wr_addr != 0).
- **Counters:** wr_addr is 10 bits and clears only in START or on reset. bit_cnt is 3 bits and wraps 7->0 at the end of each UNPACK.

## Timing
- **Reset values:**
  - State LOAD, wr_addr 0, bit_cnt 0, shift 0, result 0.
  - clr_rx_rdy/ram_we/start/tx_start 0, ram_d 0, ram_addr 0, busy 0.
- **Per byte:** the byte is accepted at cycle T; writes occur at T+1..T+8; the earliest next accept is T+9.
- **Last byte to start:** accepted at T, start pulses at T+9, with ram_addr switched to core_addr from T+9 on.
- **Done to transmit:** done at cycle D gives tx_start at D+1; result/tx_data are stable from D+1 until the next done.
- **Bytes arriving outside LOAD:**
  - clr_rx_rdy is not asserted; the byte stays pending in the receiver.
  - It is accepted on the first LOAD cycle and becomes byte 0 of the next image.
- **done outside WAIT_CORE:** ignored; result is unchanged.
- **tx_done outside WAIT_TX:** ignored.
- **done and tx_done together:** each is acted on only in its own state.
- **Reset mid-image:** a partial image is discarded; after reset the next received byte is byte 0 again.

## Test plan
- **Reset:** assert rst_n=0 mid-UNPACK -> all outputs return to reset values immediately; the next byte is written to addresses 0..7.
- **Bit mapping:** send byte 8'hA5 as byte 0 -> writes to addresses 0..7 are 1,0,1,0,0,1,0,1 on 8 consecutive cycles; one clr_rx_rdy pulse occurs in the accept cycle.
- **Full image:** send 98 bytes back-to-back with rx_rdy held -> exactly 784 writes at addresses 0..783 and exactly one start pulse, 9 cycles after the 98th accept; no writes to addresses ≥784.
- **Address mux:** in WAIT_CORE drive core_addr=10'h2A7 -> ram_addr=10'h2A7 and ram_we=0.
- **Result path:**
  - Pulse done with digit=7 -> result=7 and tx_start pulses next cycle with tx_data=8'h37.
  - tx_done returns to LOAD; busy falls in the same cycle as the transition.
- **Back-pressure:**
  - Assert rx_rdy with 8'hFF during WAIT_CORE -> no clr_rx_rdy until after tx_done.
  - The byte is then written to addresses 0..7 as all ones.
  - A stray done in LOAD leaves result unchanged.
